// File: rtl/tdc_trig_pkg.sv
// rtl/tdc_trig_pkg.sv - shared mode encodings and width constants for the trigger generator
package tdc_trig_pkg;

   // Trigger combination modes; the reserved code behaves like OFF.
   typedef enum logic [1:0] {
      MODE_OFF  = 2'b00,
      MODE_OR   = 2'b01,
      MODE_AND  = 2'b10,
      MODE_RSVD = 2'b11
   } trig_mode_e;

   // Width of the trigger window counter exported to software.
   localparam int TRIG_CNT_W = 32;

endpackage

// File: rtl/trig_chan_det.sv
// rtl/trig_chan_det.sv - per-channel hit-count change detector, coincidence window and sticky flag
module trig_chan_det #(
   parameter int CNT_W = 32,
   parameter int WIN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] hit,
   input  logic             mask,
   input  logic             prime,
   input  logic             win_en,
   input  logic             win_clr,
   input  logic [WIN_W-1:0] win_len,
   input  logic             clr_seen,
   output logic             hit_event,
   output logic             armed,
   output logic             event_q,
   output logic             seen
);

   logic [CNT_W-1:0] prev;
   logic [WIN_W-1:0] win;

   // Any change of the count (including a wrap) is an event; the prime cycle only loads prev.
   assign hit_event = (hit != prev) & mask & ~prime;

   // A channel counts as armed while its own event is present or its window is still open.
   assign armed = hit_event | (win != '0);

   // Previous-count register, loaded every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev <= '0;
      end else begin
         prev <= hit;
      end
   end

   // Coincidence window: reload on event, count down to zero, flush on fire or outside AND mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win <= '0;
      end else if (!win_en || win_clr) begin
         win <= '0;
      end else if (hit_event) begin
         win <= win_len;
      end else if (win != '0) begin
         win <= win - 1'b1;
      end
   end

   // Registered event flag and sticky seen flag; a new event beats a coincident clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         event_q <= 1'b0;
         seen    <= 1'b0;
      end else begin
         event_q <= hit_event;
         if (hit_event) begin
            seen <= 1'b1;
         end else if (clr_seen) begin
            seen <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/trig_gen_n.sv
// rtl/trig_gen_n.sv - N-channel hit-count trigger generator with OR/AND coincidence and hold stretch
module trig_gen_n
   import tdc_trig_pkg::*;
#(
   parameter int N_CH   = 2,
   parameter int CNT_W  = 32,
   parameter int HOLD_W = 8,
   parameter int WIN_W  = 4
) (
   input  logic                  SYSCLK,
   input  logic                  RESET,
   input  logic [N_CH*CNT_W-1:0] hit_count,
   input  logic [1:0]            cfg_mode,
   input  logic [N_CH-1:0]       cfg_ch_mask,
   input  logic [HOLD_W-1:0]     cfg_hold,
   input  logic [WIN_W-1:0]      cfg_win,
   input  logic                  clr_seen,
   output logic                  TRIGGER,
   output logic [TRIG_CNT_W-1:0] trig_count,
   output logic [N_CH-1:0]       ch_event,
   output logic [N_CH-1:0]       ch_seen
);

   logic              prime;
   logic              mode_or;
   logic              mode_and;
   logic [N_CH-1:0]   hit_event;
   logic [N_CH-1:0]   armed;
   logic              any_event;
   logic              all_armed;
   logic              fire;
   logic [HOLD_W-1:0] hold;
   logic [HOLD_W-1:0] hold_next;
   logic [HOLD_W-1:0] hold_load;
   logic              trig_q;

   assign mode_or  = (cfg_mode == MODE_OR);
   assign mode_and = (cfg_mode == MODE_AND);

   // Per-channel detectors.
   for (genvar g = 0; g < N_CH; g++) begin : g_chan
      trig_chan_det #(
         .CNT_W (CNT_W),
         .WIN_W (WIN_W)
      ) u_det (
         .clk       (SYSCLK),
         .rst_n     (RESET),
         .hit       (hit_count[g*CNT_W +: CNT_W]),
         .mask      (cfg_ch_mask[g]),
         .prime     (prime),
         .win_en    (mode_and),
         .win_clr   (fire),
         .win_len   (cfg_win),
         .clr_seen  (clr_seen),
         .hit_event (hit_event[g]),
         .armed     (armed[g]),
         .event_q   (ch_event[g]),
         .seen      (ch_seen[g])
      );
   end

   assign any_event = |hit_event;
   // Unmasked channels never block coincidence.
   assign all_armed = &(armed | ~cfg_ch_mask);
   // A hold of zero still stretches the trigger for one cycle.
   assign hold_load = (cfg_hold == '0) ? HOLD_W'(1) : cfg_hold;

   // Fire decision from the current mode and this cycle's events.
   always_comb begin
      fire = 1'b0;
      if (mode_or) begin
         fire = any_event;
      end else if (mode_and) begin
         fire = any_event & all_armed & (|cfg_ch_mask);
      end
   end

   // Hold counter next state: retriggerable reload on fire, flushed when the generator is off.
   always_comb begin
      hold_next = hold;
      if (!(mode_or || mode_and)) begin
         hold_next = '0;
      end else if (fire) begin
         hold_next = hold_load;
      end else if (hold != '0) begin
         hold_next = hold - 1'b1;
      end
   end

   // Prime flag: the first cycle after reset release only loads the previous counts.
   always_ff @(posedge SYSCLK or negedge RESET) begin
      if (!RESET) begin
         prime <= 1'b1;
      end else begin
         prime <= 1'b0;
      end
   end

   // Hold counter and its registered trigger decode.
   always_ff @(posedge SYSCLK or negedge RESET) begin
      if (!RESET) begin
         hold   <= '0;
         trig_q <= 1'b0;
      end else begin
         hold   <= hold_next;
         trig_q <= (hold_next != '0);
      end
   end

   // Count trigger windows opened; retriggers inside a running hold are not new windows.
   always_ff @(posedge SYSCLK or negedge RESET) begin
      if (!RESET) begin
         trig_count <= '0;
      end else if (fire && (hold == '0)) begin
         trig_count <= trig_count + 1'b1;
      end
   end

   assign TRIGGER = trig_q;

endmodule

// File: doc/trig_gen_n.md
TRIG_GEN_N -- requirements
Module: trig_gen_n

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of hit-count channels, 1..16.
REQ-002 SHALL have parameter CNT_W, default 32: width of each channel hit count.
REQ-003 SHALL have parameter HOLD_W, default 8: width of the trigger hold counter.
REQ-004 SHALL have parameter WIN_W, default 4: width of the coincidence window counter.
REQ-005 SHALL have port SYSCLK, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port RESET, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port hit_count, input, N_CH*CNT_W: channel i occupies bits [i*CNT_W +: CNT_W].
REQ-008 SHALL have port cfg_mode, input, 2: 00 OFF, 01 OR, 10 AND, 11 treated as OFF.
REQ-009 SHALL have port cfg_ch_mask, input, N_CH: 1 = channel participates.
REQ-010 SHALL have port cfg_hold, input, HOLD_W: trigger hold length in cycles; 0 treated as 1.
REQ-011 SHALL have port cfg_win, input, WIN_W: coincidence window in cycles.
REQ-012 SHALL have port clr_seen, input, 1: single-cycle clear of ch_seen.
REQ-013 SHALL have port TRIGGER, output, 1: the hold-stretched trigger.
REQ-014 SHALL have port trig_count, output, 32: number of trigger windows opened.
REQ-015 SHALL have port ch_event, output, N_CH: registered per-channel event flags.
REQ-016 SHALL have port ch_seen, output, N_CH: sticky per-channel activity flags.

Function
REQ-017 SHALL register prev[i] <= hit_count[i] every cycle; event[i] = (hit_count[i] != prev[i]) & cfg_ch_mask[i].
REQ-018 SHALL suppress all events on the first cycle after reset release (prime cycle), in which prev is only loaded.
REQ-019 SHALL drive ch_event[i] <= event[i], giving one cycle of latency.
REQ-020 SHALL, in OR mode, set fire = |event.
REQ-021 SHALL, in AND mode, give each channel a window counter win[i]:
- on event[i], load cfg_win;
- otherwise decrement, saturating at 0.
REQ-022 SHALL, in AND mode, define armed[i] = event[i] | (win[i] != 0).
REQ-023 SHALL, in AND mode, set fire = |event & (every masked channel armed) & (cfg_ch_mask != 0).
REQ-024 SHALL clear all win[i] in the cycle after a fire.
- With cfg_win = 0, only same-cycle coincidence fires.
REQ-025 SHALL run a hold counter hold:
- on fire, load max(cfg_hold, 1), retriggerably reloading even when nonzero;
- otherwise decrement, saturating at 0.
REQ-026 SHALL drive TRIGGER = (hold != 0), decoded from a register.
- TRIGGER rises on the edge after the hit_count change is presented.
- TRIGGER stays high exactly cfg_hold cycles after the last fire.
REQ-027 SHALL increment trig_count, wrapping modulo 2^32, only on a fire while hold == 0.
- Retriggers during hold do not count.
REQ-028 SHALL, when cfg_mode is OFF or 11:
- force fire = 0;
- clear hold and all win[i] on the next edge, so TRIGGER is low one cycle later;
- continue updating prev, ch_event and ch_seen.
REQ-029 SHALL set ch_seen[i] on event[i] and clear it on clr_seen.
- If set and clear coincide, set wins.
REQ-030 SHALL sample cfg_* every cycle with no shadowing.
- A cfg_win or cfg_hold change affects only subsequent loads.
REQ-031 SHALL treat a wrap of hit_count (all-ones to 0) as a normal change event.

Reset
REQ-032 SHALL, while RESET = 0, asynchronously set:
- TRIGGER = 0, trig_count = 0, ch_event = 0, ch_seen = 0;
- hold = 0, all win = 0, all prev = 0, prime flag = 1.
REQ-033 SHALL, on reset assertion mid-hold, drop TRIGGER immediately and not complete the hold.

Structure
REQ-034 SHALL place the cfg_mode encodings (OFF/OR/AND) and the 32-bit trig_count width constant in shared package tdc_trig_pkg.
REQ-035 SHALL implement the per-channel logic (prev, event, win counter, ch_seen) as sub-module trig_chan_det, instantiated N_CH times via generate.

Verification
REQ-036 SHALL cover OR mode with N_CH=2, cfg_hold=255, mask=11:
- stimulus: ch0 count 5->6 once;
- response: TRIGGER high exactly 255 cycles, trig_count=1, ch_seen=01.
REQ-037 SHALL cover OR retrigger with cfg_hold=10:
- stimulus: ch1 changes at cycles 0 and 6;
- response: TRIGGER high 16 continuous cycles, trig_count=1.
REQ-038 SHALL cover AND mode with cfg_win=3, mask=11:
- stimulus A: ch0 changes at t, ch1 at t+3;
- response A: fire at t+3, trig_count=1;
- stimulus B: ch1 at t+4;
- response B: no trigger.
REQ-039 SHALL cover AND mode with mask=01:
- stimulus: ch0 change;
- response: trigger.
- With mask=00, no trigger ever fires.
REQ-040 SHALL cover reset and prime:
- stimulus: release RESET with hit_count=0x1234;
- response: no event or trigger.
- Asserting RESET mid-hold drops TRIGGER asynchronously and zeroes trig_count.
REQ-041 SHALL cover OFF mode and clr_seen:
- stimulus: cfg_mode -> 00 during hold;
- response: TRIGGER low within 1 cycle, ch_seen still updates.
- clr_seen coincident with an event leaves ch_seen set.
